// File: rtl/in_port_ctrl_pkg.sv
// Shared I/O definitions for the input-port window: address map, status bit
// positions and the status-word packing helper.
package in_port_ctrl_pkg;

  localparam logic [1:0] IN_ADDR_PORT0  = 2'd0;
  localparam logic [1:0] IN_ADDR_PORT1  = 2'd1;
  localparam logic [1:0] IN_ADDR_STATUS = 2'd2;

  localparam int ST_PENDING   = 0;
  localparam int ST_IRQ_EN    = 1;
  localparam int ST_EVCNT_LSB = 8;
  localparam int ST_SUB       = 16;

  localparam logic [7:0] EVCNT_MAX = 8'd255;

  function automatic logic [31:0] status_word(input logic       sub,
                                              input logic [7:0] evcnt,
                                              input logic       irq_en,
                                              input logic       pending);
    logic [31:0] w;
    w                             = '0;
    w[ST_SUB]                     = sub;
    w[ST_EVCNT_LSB+7:ST_EVCNT_LSB] = evcnt;
    w[ST_IRQ_EN]                  = irq_en;
    w[ST_PENDING]                 = pending;
    return w;
  endfunction

endpackage

// File: rtl/in_port_ctrl_debounce.sv
// in_debounce: 2-FF synchroniser followed by a stable-count debouncer.
// RST_VAL sets the reset level of every internal register.
module in_debounce #(
  parameter int             W               = 4,
  parameter int             DEBOUNCE_CYCLES = 16,
  parameter int             CNT_W           = 20,
  parameter logic [W-1:0]   RST_VAL         = '0
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     meta_reg;
  logic [W-1:0]     sync_reg;
  logic [W-1:0]     last_reg;
  logic [W-1:0]     stable_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      meta_reg   <= RST_VAL;
      sync_reg   <= RST_VAL;
      last_reg   <= RST_VAL;
      stable_reg <= RST_VAL;
      cnt_reg    <= '0;
    end else begin
      meta_reg <= raw;
      sync_reg <= meta_reg;
      last_reg <= sync_reg;
      // Any movement of the sampled value restarts the stability window.
      if (sync_reg == stable_reg || sync_reg != last_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= sync_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign stable = stable_reg;

endmodule

// File: rtl/in_port_ctrl.sv
// in_port_ctrl: debounced switch/key inputs with a sticky, counted key-press
// event and clear-on-read status. Optional irq output under IN_PORT_IRQ_EN.
module in_port_ctrl
  import in_port_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  in_port0,
  input  logic [3:0]  in_port1,
  input  logic        in_port_sub,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  output logic [31:0] rdata
`ifdef IN_PORT_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic [3:0] port0_stable;
  logic [3:0] port1_stable;
  logic       sub_stable;

  in_debounce #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RST_VAL(4'h0))
    u_db_port0 (.clock(clock), .resetn(resetn), .raw(in_port0), .stable(port0_stable));

  in_debounce #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RST_VAL(4'h0))
    u_db_port1 (.clock(clock), .resetn(resetn), .raw(in_port1), .stable(port1_stable));

  // Key idles released (1) so reset never produces a falling edge.
  in_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RST_VAL(1'b1))
    u_db_sub (.clock(clock), .resetn(resetn), .raw(in_port_sub), .stable(sub_stable));

  logic       sub_prev_reg;
  logic       pending_reg;
  logic [7:0] evcnt_reg;
  logic       press_event;
  logic       status_clr;
  logic       irq_en;

  assign press_event = sub_prev_reg & ~sub_stable;
  assign status_clr  = rd_en && (addr == IN_ADDR_STATUS);

`ifdef IN_PORT_IRQ_EN
  assign irq_en = 1'b1;
  assign irq    = pending_reg;
`else
  assign irq_en = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sub_prev_reg <= 1'b1;
      pending_reg  <= 1'b0;
      evcnt_reg    <= 8'd0;
    end else begin
      sub_prev_reg <= sub_stable;
      // A press landing on the clearing read survives as a fresh single event.
      if (status_clr) begin
        pending_reg <= press_event;
        evcnt_reg   <= press_event ? 8'd1 : 8'd0;
      end else if (press_event) begin
        pending_reg <= 1'b1;
        if (evcnt_reg != EVCNT_MAX)
          evcnt_reg <= evcnt_reg + 8'd1;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      IN_ADDR_PORT0:  rdata = {28'd0, port0_stable};
      IN_ADDR_PORT1:  rdata = {28'd0, port1_stable};
      IN_ADDR_STATUS: rdata = status_word(sub_stable, evcnt_reg, irq_en, pending_reg);
      default:        rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_in_port_ctrl.sv
// Self-checking bench for in_port_ctrl with DEBOUNCE_CYCLES=4; table-driven
// register-map reads plus directed multi-cycle sequences.
module tb_in_port_ctrl;

  logic        clock;
  logic        resetn;
  logic [3:0]  in_port0;
  logic [3:0]  in_port1;
  logic        in_port_sub;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] rdata;
`ifdef IN_PORT_IRQ_EN
  logic        irq;
  localparam logic [31:0] IEN = 32'h0000_0002;
`else
  localparam logic [31:0] IEN = 32'h0000_0000;
`endif

  in_port_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .clock(clock),
    .resetn(resetn),
    .in_port0(in_port0),
    .in_port1(in_port1),
    .in_port_sub(in_port_sub),
    .rd_en(rd_en),
    .addr(addr),
    .rdata(rdata)
`ifdef IN_PORT_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic        rd;
    logic [1:0]  a;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      pass_cnt++;
      $display("check %s: %h", name, act);
    end
  endtask

  // Combinational read without clocking (rd_en low).
  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    rd_en = 1'b0;
    addr  = a;
    #1;
    d = rdata;
  endtask

  // One-cycle load: value seen before the edge, then the edge applies side effects.
  task automatic bus_read(input logic rd, input logic [1:0] a, output logic [31:0] d);
    rd_en = rd;
    addr  = a;
    #1;
    d = rdata;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic press(input int n_low, input int n_high);
    in_port_sub = 1'b0;
    repeat (n_low) tick();
    in_port_sub = 1'b1;
    repeat (n_high) tick();
  endtask

  task automatic check_irq(input string name, input logic exp);
`ifdef IN_PORT_IRQ_EN
    check(name, {31'd0, irq}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", name);
`endif
  endtask

  logic [31:0] d;

  initial begin
    tbl[0] = '{1'b0, 2'd0, 32'h0000_000A};
    tbl[1] = '{1'b1, 2'd1, 32'h0000_0003};
    tbl[2] = '{1'b1, 2'd3, 32'h0000_0000};
    tbl[3] = '{1'b0, 2'd2, 32'h0001_0201 | IEN};
    tbl[4] = '{1'b1, 2'd0, 32'h0000_000A};
    tbl[5] = '{1'b1, 2'd2, 32'h0001_0201 | IEN};
    tbl[6] = '{1'b0, 2'd2, 32'h0001_0000 | IEN};
    tbl[7] = '{1'b1, 2'd2, 32'h0001_0000 | IEN};

    resetn      = 1'b0;
    in_port0    = 4'h0;
    in_port1    = 4'h0;
    in_port_sub = 1'b1;
    rd_en       = 1'b0;
    addr        = 2'd0;
    repeat (2) tick();

    // Reset state
    peek(2'd0, d);  check("reset_addr0", d, 32'h0);
    peek(2'd2, d);  check("reset_status", d, 32'h0001_0000 | IEN);
    check_irq("reset_irq", 1'b0);
    resetn = 1'b1;
    repeat (3) tick();
    peek(2'd2, d);  check("post_reset_no_event", d, 32'h0001_0000 | IEN);

    // Debounce settle: visible exactly 7 edges after the change
    in_port0 = 4'hA;
    for (int i = 1; i <= 7; i++) begin
      tick();
      peek(2'd0, d);
      check($sformatf("settle_edge%0d", i), d, (i < 7) ? 32'h0 : 32'hA);
    end

    // Glitch rejection: 3-cycle pulse
    in_port1 = 4'h5;
    repeat (3) tick();
    in_port1 = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick();
      peek(2'd1, d);
      check($sformatf("glitch_cyc%0d", i), d, 32'h0);
    end
    in_port1 = 4'h3;
    repeat (10) tick();

    // Key event: two presses
    press(10, 10);
    press(10, 10);
    check_irq("key_irq", 1'b1);

    // Register map table with clear-on-read
    for (int i = 0; i < 8; i++) begin
      bus_read(tbl[i].rd, tbl[i].a, d);
      check($sformatf("map_vec%0d_rd%0d_a%0d", i, tbl[i].rd, tbl[i].a), d, tbl[i].exp);
    end
    check_irq("irq_cleared", 1'b0);

    // Clear/event collision: build evcnt=2, then read on the event edge
    press(10, 10);
    press(10, 10);
    in_port_sub = 1'b0;
    repeat (7) tick();
    bus_read(1'b1, 2'd2, d);
    check("collide_pre_clear", d, 32'h0000_0201 | IEN);
    peek(2'd2, d);
    check("collide_after", d, 32'h0000_0101 | IEN);
    check_irq("collide_irq", 1'b1);
    in_port_sub = 1'b1;
    repeat (10) tick();
    bus_read(1'b1, 2'd2, d);
    check("collide_release", d, 32'h0001_0101 | IEN);
    bus_read(1'b1, 2'd2, d);
    check("collide_cleared", d, 32'h0001_0000 | IEN);

    // Saturation
    for (int i = 0; i < 260; i++) press(10, 10);
    peek(2'd2, d);
    check("saturate_255", d, 32'h0001_FF01 | IEN);

    // Reset in the middle of a port0 debounce
    in_port0 = 4'h5;
    repeat (4) tick();
    resetn = 1'b0;
    repeat (2) tick();
    peek(2'd0, d);  check("midrst_addr0", d, 32'h0);
    peek(2'd2, d);  check("midrst_status", d, 32'h0001_0000 | IEN);
    check_irq("midrst_irq", 1'b0);
    resetn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      peek(2'd0, d);
      check($sformatf("rerun_edge%0d", i), d, (i < 7) ? 32'h0 : 32'h5);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
